// File: rtl/inv_sub_bytes_seq.sv
// AES InvSubBytes on a 128-bit state: LANES composite-field GF((2^4)^2) S-box lanes, 2-stage, time-multiplexed.
// Define SUBBYTES_FWD_EN to add a fwd input that reuses the inversion core for the forward S-box.
module inv_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
`ifdef SUBBYTES_FWD_EN
  input  logic         fwd,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  localparam int NCHUNK = 16 / LANES;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);
  // y^2 = y + LAMBDA is irreducible over GF(16) (x^4+x+1) because trace(LAMBDA) = 1.
  localparam logic [3:0] LAMBDA = 4'hC;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++)
      if (b[i]) p = p ^ (7'(a) << i);
    return {p[3] ^ p[6], p[2] ^ p[5] ^ p[6], p[1] ^ p[4] ^ p[5], p[0] ^ p[4]};
  endfunction

  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gf16_mul(a, a);
    a4 = gf16_mul(a2, a2);
    a8 = gf16_mul(a4, a4);
    return gf16_mul(gf16_mul(a2, a4), a8);
  endfunction

  function automatic logic [7:0] cmul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh;
    hh = gf16_mul(a[7:4], b[7:4]);
    return {hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]),
            gf16_mul(hh, LAMBDA) ^ gf16_mul(a[3:0], b[3:0])};
  endfunction

  // Column i of a basis-change matrix holds the image of bit i.
  function automatic logic [7:0] apply_map(input logic [7:0] x, input logic [63:0] m);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (x[i]) r = r ^ m[8*i +: 8];
    return r;
  endfunction

  // Iso map: AES x^i goes to beta^i, beta being a root of x^8+x^4+x^3+x+1 in the composite field.
  function automatic logic [63:0] build_iso();
    logic [63:0] m, cand;
    logic [7:0]  p;
    logic        found;
    m     = '0;
    cand  = '0;
    found = 1'b0;
    for (int c = 2; c < 256; c++) begin
      if (!found) begin
        p = 8'h01;
        for (int i = 0; i < 8; i++) begin
          cand[8*i +: 8] = p;
          p = cmul(p, 8'(c));
        end
        if ((p ^ cand[39:32] ^ cand[31:24] ^ cand[15:8] ^ cand[7:0]) == 8'h00) begin
          m     = cand;
          found = 1'b1;
        end
      end
    end
    return m;
  endfunction

  function automatic logic [63:0] build_iso_inv(input logic [63:0] m);
    logic [63:0] inv;
    logic [7:0]  y;
    inv = '0;
    for (int x = 1; x < 256; x++) begin
      y = apply_map(8'(x), m);
      for (int j = 0; j < 8; j++)
        if (y == (8'h01 << j)) inv[8*j +: 8] = 8'(x);
    end
    return inv;
  endfunction

  localparam logic [63:0] ISO     = build_iso();
  localparam logic [63:0] ISO_INV = build_iso_inv(ISO);

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

`ifdef SUBBYTES_FWD_EN
  function automatic logic [7:0] fwd_affine(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction
`endif

  // Stage-1 word {h, h^l, d}: inverse of (h*y + l) is (h*y + (h^l)) * d^-1.
  function automatic logic [11:0] lane_front(input logic [7:0] b);
    logic [7:0] m;
    m = apply_map(b, ISO);
    return {m[7:4], m[7:4] ^ m[3:0],
            gf16_mul(gf16_mul(m[7:4], m[7:4]), LAMBDA) ^ gf16_mul(m[7:4], m[3:0]) ^ gf16_mul(m[3:0], m[3:0])};
  endfunction

  function automatic logic [7:0] lane_back(input logic [11:0] s);
    logic [3:0] dinv;
    dinv = gf16_inv(s[3:0]);
    return apply_map({gf16_mul(s[11:8], dinv), gf16_mul(s[7:4], dinv)}, ISO_INV);
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_HOLD} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt, r_s1_cnt, r_s2_cnt;
  logic            r_s1_vld, r_s2_vld;
  logic            r_in_ready, r_out_valid, r_busy;
  logic [7:0]      r_buf [16];
  logic [7:0]      r_out [16];
  logic [11:0]     r_s1 [LANES];
  logic [7:0]      r_s2 [LANES];
  logic [7:0]      w_in_bytes [16];
  logic [7:0]      w_lane_x [LANES];
  logic [11:0]     w_s1_next [LANES];
  logic [7:0]      w_s2_next [LANES];
`ifdef SUBBYTES_FWD_EN
  logic            r_fwd;
`endif

  for (genvar g = 0; g < 16; g++) begin : g_bytes
    assign w_in_bytes[g]            = in_state[127-8*g -: 8];
    assign out_state[127-8*g -: 8]  = r_out[g];
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_lane_x[l] = r_buf[4'(int'(r_cnt) * LANES + l)];
`ifdef SUBBYTES_FWD_EN
      w_s1_next[l] = lane_front(r_fwd ? w_lane_x[l] : inv_affine(w_lane_x[l]));
      w_s2_next[l] = r_fwd ? fwd_affine(lane_back(r_s1[l])) : lane_back(r_s1[l]);
`else
      w_s1_next[l] = lane_front(inv_affine(w_lane_x[l]));
      w_s2_next[l] = lane_back(r_s1[l]);
`endif
    end
  end

  // NOTE: pure datapath registers carry no reset; the valid bits below decide when their contents matter.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && in_valid) begin
      r_buf <= w_in_bytes;
`ifdef SUBBYTES_FWD_EN
      r_fwd <= fwd;
`endif
    end
    r_s1_cnt <= r_cnt;
    r_s2_cnt <= r_s1_cnt;
    r_s1     <= w_s1_next;
    r_s2     <= w_s2_next;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_s1_vld    <= 1'b0;
      r_s2_vld    <= 1'b0;
      r_out       <= '{default: '0};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_s1_vld <= (r_state == S_ISSUE);
      r_s2_vld <= r_s1_vld;
      if (r_s2_vld)
        for (int l = 0; l < LANES; l++)
          r_out[4'(int'(r_s2_cnt) * LANES + l)] <= r_s2[l];
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_cnt      <= '0;
          r_state    <= S_ISSUE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b1;
        end
        S_ISSUE: begin
          if (r_cnt == LAST) r_state <= S_DRAIN;
          else               r_cnt   <= r_cnt + 1'b1;
        end
        S_DRAIN: if (r_s2_vld && r_s2_cnt == LAST) begin
          r_state     <= S_HOLD;
          r_out_valid <= 1'b1;
        end
        S_HOLD: if (out_ready) begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench for inv_sub_bytes_seq at LANES=4 (main), 1 and 16, against a plain GF(2^8) reference model.
// Exercises the fwd mode as well when SUBBYTES_FWD_EN is defined.
module tb_inv_sub_bytes_seq;
  localparam int LAT [3] = '{6, 18, 3};

  logic         clk;
  logic         rst;
  logic         vld  [3];
  logic         ird  [3];
  logic [127:0] sti  [3];
  logic         ovld [3];
  logic         rdy  [3];
  logic [127:0] ost  [3];
  logic         bsy  [3];
`ifdef SUBBYTES_FWD_EN
  logic         fwi;
`endif

  int n_pass  = 0;
  int n_total = 0;

  inv_sub_bytes_seq #(.LANES(4)) u_l4 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(ird[0]), .in_state(sti[0]),
`ifdef SUBBYTES_FWD_EN
    .fwd(fwi),
`endif
    .out_valid(ovld[0]), .out_ready(rdy[0]), .out_state(ost[0]), .busy(bsy[0]));

  inv_sub_bytes_seq #(.LANES(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(ird[1]), .in_state(sti[1]),
`ifdef SUBBYTES_FWD_EN
    .fwd(fwi),
`endif
    .out_valid(ovld[1]), .out_ready(rdy[1]), .out_state(ost[1]), .busy(bsy[1]));

  inv_sub_bytes_seq #(.LANES(16)) u_l16 (
    .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(ird[2]), .in_state(sti[2]),
`ifdef SUBBYTES_FWD_EN
    .fwd(fwi),
`endif
    .out_valid(ovld[2]), .out_ready(rdy[2]), .out_state(ost[2]), .busy(bsy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: GF(2^8) arithmetic straight from the field definition.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
    return (x << k) | (x >> (8 - k));
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return ginv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] model_inv(input logic [127:0] st);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r  = {r[119:0], inv_sbox(st[127:120])};
      st = st << 8;
    end
    return r;
  endfunction

`ifdef SUBBYTES_FWD_EN
  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] v, y, c;
    v = ginv(x);
    c = 8'h63;
    for (int i = 0; i < 8; i++)
      y[i] = v[i] ^ v[(i + 4) % 8] ^ v[(i + 5) % 8] ^ v[(i + 6) % 8] ^ v[(i + 7) % 8] ^ c[i];
    return y;
  endfunction

  function automatic logic [127:0] model_fwd(input logic [127:0] st);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r  = {r[119:0], fwd_sbox(st[127:120])};
      st = st << 8;
    end
    return r;
  endfunction
`endif

  function automatic logic [127:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_out(input int k, output int edges);
    edges = 0;
    while (ovld[k] !== 1'b1 && edges < 200) begin
      @(negedge clk);
      edges++;
    end
  endtask

  // One full transaction on DUT k with out_ready already high; starts and ends at a negedge in IDLE.
  task automatic run_txn(input int k, input logic [127:0] st, input logic [127:0] exp, input string tag);
    int e;
    check($sformatf("%s/ready_pre", tag), 128'(ird[k]), 128'(1));
    vld[k] = 1'b1;
    sti[k] = st;
    @(negedge clk);
    vld[k] = 1'b0;
    sti[k] = ~st;
    check($sformatf("%s/ready_drop", tag), 128'(ird[k]), 128'(0));
    check($sformatf("%s/busy", tag), 128'(bsy[k]), 128'(1));
    wait_out(k, e);
    check($sformatf("%s/latency", tag), 128'(e), 128'(LAT[k]));
    check($sformatf("%s/data", tag), ost[k], exp);
    @(negedge clk);
    check($sformatf("%s/valid_low", tag), 128'(ovld[k]), 128'(0));
    check($sformatf("%s/ready_back", tag), 128'(ird[k]), 128'(1));
    check($sformatf("%s/data_kept", tag), ost[k], exp);
  endtask

  localparam logic [128*3-1:0] KNOWN = {128'h637c777bf26b6fc53001672bfed7ab76,
                                        128'h000102030405060708090a0b0c0d0e0f,
                                        {8'h63, 8'h7c, 8'hed, 8'hf2, 8'h16, {11{8'h63}}}};
  localparam logic [127:0] CORNER_EXP = {8'h00, 8'h01, 8'h53, 8'h04, 8'hff, {11{8'h00}}};

  initial begin
    logic [127:0] sbox_in, sbox_out, corner_in, a, b, exp_a;
    int e;
    sbox_in   = KNOWN[383:256];
    sbox_out  = KNOWN[255:128];
    corner_in = KNOWN[127:0];
    rst = 1'b1;
`ifdef SUBBYTES_FWD_EN
    fwi = 1'b0;
`endif
    for (int k = 0; k < 3; k++) begin
      vld[k] = 1'b0;
      rdy[k] = 1'b1;
      sti[k] = '0;
    end

    // Reset state on every instance.
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset%0d/in_ready", k), 128'(ird[k]), 128'(1));
      check($sformatf("reset%0d/out_valid", k), 128'(ovld[k]), 128'(0));
      check($sformatf("reset%0d/busy", k), 128'(bsy[k]), 128'(0));
      check($sformatf("reset%0d/out_state", k), ost[k], 128'(0));
    end
    rst = 1'b0;
    @(negedge clk);

    // Known S-box row, then byte corners on all three lane counts.
    run_txn(0, sbox_in, sbox_out, "known_l4");
    run_txn(0, corner_in, CORNER_EXP, "corner_l4");
    run_txn(1, corner_in, CORNER_EXP, "corner_l1");
    run_txn(2, corner_in, CORNER_EXP, "corner_l16");

    // Random states against the model.
    for (int i = 0; i < 6; i++) begin
      a = rand_state();
      run_txn(0, a, model_inv(a), $sformatf("rand_l4_%0d", i));
    end
    for (int i = 0; i < 2; i++) begin
      a = rand_state();
      run_txn(1, a, model_inv(a), $sformatf("rand_l1_%0d", i));
      a = rand_state();
      run_txn(2, a, model_inv(a), $sformatf("rand_l16_%0d", i));
    end

    // Backpressure: result held for 20 cycles, a stray in_valid pulse is ignored.
    a     = rand_state();
    b     = rand_state();
    exp_a = model_inv(a);
    rdy[0] = 1'b0;
    vld[0] = 1'b1;
    sti[0] = a;
    @(negedge clk);
    vld[0] = 1'b0;
    wait_out(0, e);
    check("bp/latency", 128'(e), 128'(6));
    check("bp/data", ost[0], exp_a);
    for (int c = 0; c < 20; c++) begin
      vld[0] = (c == 5);
      sti[0] = b;
      @(negedge clk);
      check($sformatf("bp/hold_valid_%0d", c), 128'(ovld[0]), 128'(1));
      check($sformatf("bp/hold_data_%0d", c), ost[0], exp_a);
      check($sformatf("bp/hold_ready_%0d", c), 128'(ird[0]), 128'(0));
    end
    vld[0] = 1'b0;
    rdy[0] = 1'b1;
    @(negedge clk);
    check("bp/release_valid", 128'(ovld[0]), 128'(0));
    check("bp/release_ready", 128'(ird[0]), 128'(1));
    repeat (3) @(negedge clk);
    check("bp/no_second_busy", 128'(bsy[0]), 128'(0));
    check("bp/no_second_data", ost[0], exp_a);

    // Reset two cycles after capture, then a clean transaction.
    vld[0] = 1'b1;
    sti[0] = rand_state();
    @(negedge clk);
    vld[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst/in_ready", 128'(ird[0]), 128'(1));
    check("midrst/out_valid", 128'(ovld[0]), 128'(0));
    check("midrst/busy", 128'(bsy[0]), 128'(0));
    check("midrst/out_state", ost[0], 128'(0));
    rst = 1'b0;
    @(negedge clk);
    a = rand_state();
    run_txn(0, a, model_inv(a), "after_rst");

    // Back-to-back with in_valid held high.
    a = rand_state();
    b = rand_state();
    vld[0] = 1'b1;
    sti[0] = a;
    @(negedge clk);
    check("b2b/first_capture", 128'(ird[0]), 128'(0));
    sti[0] = b;
    wait_out(0, e);
    check("b2b/first_latency", 128'(e), 128'(6));
    check("b2b/first_data", ost[0], model_inv(a));
    @(negedge clk);
    check("b2b/release_valid", 128'(ovld[0]), 128'(0));
    check("b2b/release_ready", 128'(ird[0]), 128'(1));
    @(negedge clk);
    check("b2b/second_capture", 128'(ird[0]), 128'(0));
    vld[0] = 1'b0;
    wait_out(0, e);
    check("b2b/second_latency", 128'(e), 128'(6));
    check("b2b/second_data", ost[0], model_inv(b));
    @(negedge clk);
    check("b2b/second_release", 128'(ovld[0]), 128'(0));

`ifdef SUBBYTES_FWD_EN
    // Forward mode on the shared core, then round trip back through the inverse.
    fwi = 1'b1;
    run_txn(0, sbox_out, sbox_in, "fwd_known");
    fwi = 1'b0;
    run_txn(0, sbox_in, sbox_out, "fwd_roundtrip");
    fwi = 1'b1;
    a = rand_state();
    run_txn(1, a, model_fwd(a), "fwd_rand_l1");
    a = rand_state();
    run_txn(2, a, model_fwd(a), "fwd_rand_l16");
    fwi = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
